// File: rtl/common_pkg.sv
// Shared types and constants for the front end.
// Imported by the fetch stage and its IF/ID register.
package common;

  typedef logic [31:0] instruction_type;

  localparam instruction_type NOP_INSTRUCTION = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic [1:0] {
    FETCH,
    WAIT,
    HOLD,
    DISCARD
  } fetch_state_type;

  typedef struct packed {
    logic            valid;
    logic [31:0]     pc;
    instruction_type instr;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if_id.sv
// IF/ID pipeline register: holds valid, pc and instruction.
// Clear wins over load; a cleared slot carries a NOP.
module if_id_register
  import common::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   load,
  input  logic   clear,
  input  if_id_t d,
  output if_id_t q
);

  // Capture a new instruction or squash the slot
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q.valid <= 1'b0;
      q.pc    <= 32'h0;
      q.instr <= NOP_INSTRUCTION;
    end else if (clear) begin
      q.valid <= 1'b0;
      q.pc    <= 32'h0;
      q.instr <= NOP_INSTRUCTION;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: one outstanding request, stall buffer,
// redirect handling and the IF/ID register.
module fetch_stage
  import common::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            branch_taken,
  input  logic [31:0]     branch_target,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_rvalid,
  input  logic [31:0]     imem_rdata,
  output logic            valid_out,
  output logic [31:0]     pc_out,
  output instruction_type instruction_out
);

  fetch_state_type state;
  logic [31:0]     pc;
  instruction_type buf_q;

  logic   redirect;
  logic   if_load;
  logic   if_clear;
  if_id_t if_d;
  if_id_t if_q;

  assign redirect  = branch_taken | flush;
  assign imem_req  = rst & (state == FETCH);
  assign imem_addr = pc;

  // Decide when the IF/ID slot takes a word and from where
  always_comb begin
    if_clear  = redirect;
    if_load   = 1'b0;
    if_d.valid = 1'b1;
    if_d.pc    = pc;
    if_d.instr = imem_rdata;
    if (!redirect && !stall) begin
      unique case (1'b1)
        (state == WAIT): if_load = imem_rvalid;
        (state == HOLD): begin
          if_load    = 1'b1;
          if_d.instr = buf_q;
        end
        default: if_load = 1'b0;
      endcase
    end
  end

  // Fetch FSM, program counter and one-entry stall buffer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= FETCH;
      pc    <= RESET_PC;
      buf_q <= NOP_INSTRUCTION;
    end else begin
      unique case (state)
        FETCH: begin
          state <= redirect ? DISCARD : WAIT;
        end
        WAIT: begin
          if (redirect) begin
            state <= imem_rvalid ? FETCH : DISCARD;
          end else if (imem_rvalid) begin
            if (stall) begin
              buf_q <= imem_rdata;
              state <= HOLD;
            end else begin
              pc    <= pc + 32'd4;
              state <= FETCH;
            end
          end
        end
        HOLD: begin
          if (redirect) begin
            state <= FETCH;
          end else if (!stall) begin
            pc    <= pc + 32'd4;
            state <= FETCH;
          end
        end
        DISCARD: begin
          if (imem_rvalid) state <= FETCH;
        end
        default: state <= FETCH;
      endcase
      if (redirect) begin
        buf_q <= NOP_INSTRUCTION;
        if (branch_taken) pc <= branch_target & ~32'h3;
      end
    end
  end

  if_id_register u_if_id (
    .clk   (clk),
    .rst   (rst),
    .load  (if_load),
    .clear (if_clear),
    .d     (if_d),
    .q     (if_q)
  );

  assign valid_out       = if_q.valid;
  assign pc_out          = if_q.pc;
  assign instruction_out = if_q.instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed and randomized checks of fetch_stage against a
// memory model and an in-order delivery reference.
module tb_fetch_stage;
  import common::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        valid_out;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;

  logic        man_rvalid = 1'b0;
  logic [31:0] man_rdata = 32'h0;
  logic        auto_mem = 1'b0;
  logic        auto_rvalid;
  logic [31:0] auto_rdata;
  int          cnt = 0;
  logic [31:0] pend_addr = 32'h0;

  logic        rst1 = 1'b0;
  logic        zero1 = 1'b0;
  logic [31:0] zero32 = 32'h0;
  logic        req1;
  logic [31:0] addr1;
  logic        rvalid1 = 1'b0;
  logic [31:0] rdata1 = 32'h0;
  logic        valid1;
  logic [31:0] pcout1;
  logic [31:0] instr1;

  int vectors = 0;
  int errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F00};
  endfunction

  assign imem_rvalid = auto_mem ? auto_rvalid : man_rvalid;
  assign imem_rdata  = auto_mem ? auto_rdata : man_rdata;
  assign auto_rvalid = (cnt == 1);
  assign auto_rdata  = mem(pend_addr);

  // Memory with a random 1..3 cycle latency per request
  always @(posedge clk) begin
    if (!rst) begin
      cnt <= 0;
    end else if (imem_req) begin
      cnt <= int'($urandom_range(1, 3));
      pend_addr <= imem_addr;
    end else if (cnt > 0) begin
      cnt <= cnt - 1;
    end
  end

  fetch_stage u0 (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .flush           (flush),
    .branch_taken    (branch_taken),
    .branch_target   (branch_target),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .valid_out       (valid_out),
    .pc_out          (pc_out),
    .instruction_out (instruction_out)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) u1 (
    .clk             (clk),
    .rst             (rst1),
    .stall           (zero1),
    .flush           (zero1),
    .branch_taken    (zero1),
    .branch_target   (zero32),
    .imem_req        (req1),
    .imem_addr       (addr1),
    .imem_rvalid     (rvalid1),
    .imem_rdata      (rdata1),
    .valid_out       (valid1),
    .pc_out          (pcout1),
    .instruction_out (instr1)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  logic [31:0] next_pc;
  logic        prev_valid;
  logic [31:0] prev_pc;
  logic [31:0] prev_instr;
  logic        redir_last;
  logic        hold_last;
  logic        delivered;
  int          ndeliv;
  int          r;

  initial begin
    step();
    step();

    // wrap-around instance
    rst1 = 1'b1;
    #1;
    chk("wrap_req0", {31'h0, req1}, 32'h1);
    chk("wrap_addr0", addr1, 32'hFFFF_FFFC);
    step();
    rvalid1 = 1'b1;
    rdata1  = 32'h00A0_0113;
    step();
    rvalid1 = 1'b0;
    chk("wrap_valid", {31'h0, valid1}, 32'h1);
    chk("wrap_pc", pcout1, 32'hFFFF_FFFC);
    chk("wrap_instr", instr1, 32'h00A0_0113);
    chk("wrap_req1", {31'h0, req1}, 32'h1);
    chk("wrap_addr1", addr1, 32'h0);
    rst1 = 1'b0;

    // reset state
    chk("rst_req", {31'h0, imem_req}, 32'h0);
    chk("rst_valid", {31'h0, valid_out}, 32'h0);
    chk("rst_pc", pc_out, 32'h0);
    chk("rst_instr", instruction_out, NOP);

    // release and 1-cycle memory
    rst = 1'b1;
    #1;
    chk("first_req", {31'h0, imem_req}, 32'h1);
    chk("first_addr", imem_addr, 32'h0);
    step();
    man_rvalid = 1'b1;
    man_rdata  = 32'h0050_0093;
    step();
    man_rvalid = 1'b0;
    chk("t1_valid", {31'h0, valid_out}, 32'h1);
    chk("t1_pc", pc_out, 32'h0);
    chk("t1_instr", instruction_out, 32'h0050_0093);
    chk("t1_next_addr", imem_addr, 32'h4);

    // stall while a response arrives
    step();
    stall = 1'b1;
    man_rvalid = 1'b1;
    man_rdata  = 32'h1111_1111;
    for (int k = 0; k < 3; k++) begin
      step();
      man_rvalid = 1'b0;
      chk("t2_state", 32'(u0.state), 32'(HOLD));
      chk("t2_valid", {31'h0, valid_out}, 32'h1);
      chk("t2_pc", pc_out, 32'h0);
      chk("t2_instr", instruction_out, 32'h0050_0093);
      chk("t2_noreq", {31'h0, imem_req}, 32'h0);
    end
    stall = 1'b0;
    step();
    chk("t2_rel_pc", pc_out, 32'h4);
    chk("t2_rel_instr", instruction_out, 32'h1111_1111);
    chk("t2_rel_addr", imem_addr, 32'h8);

    // branch with a response still pending
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0103;
    step();
    branch_taken = 1'b0;
    chk("t3_valid", {31'h0, valid_out}, 32'h0);
    chk("t3_instr", instruction_out, NOP);
    chk("t3_noreq", {31'h0, imem_req}, 32'h0);
    man_rvalid = 1'b1;
    man_rdata  = 32'hDEAD_BEEF;
    step();
    man_rvalid = 1'b0;
    chk("t3_req", {31'h0, imem_req}, 32'h1);
    chk("t3_addr", imem_addr, 32'h100);
    chk("t3_valid2", {31'h0, valid_out}, 32'h0);
    step();
    man_rvalid = 1'b1;
    man_rdata  = 32'h2222_2222;
    step();
    man_rvalid = 1'b0;
    chk("t3_pc", pc_out, 32'h100);
    chk("t3_instr2", instruction_out, 32'h2222_2222);

    // branch, stall and response in one cycle
    step();
    branch_taken  = 1'b1;
    branch_target = 32'h0000_0200;
    stall = 1'b1;
    man_rvalid = 1'b1;
    man_rdata  = 32'h3333_3333;
    step();
    branch_taken = 1'b0;
    stall = 1'b0;
    man_rvalid = 1'b0;
    chk("t4_valid", {31'h0, valid_out}, 32'h0);
    chk("t4_instr", instruction_out, NOP);
    chk("t4_state", 32'(u0.state), 32'(FETCH));
    chk("t4_addr", imem_addr, 32'h200);

    // flush alone keeps pc
    step();
    flush = 1'b1;
    step();
    flush = 1'b0;
    man_rvalid = 1'b1;
    man_rdata  = 32'h5555_5555;
    step();
    man_rvalid = 1'b0;
    chk("t5_addr", imem_addr, 32'h200);
    chk("t5_valid", {31'h0, valid_out}, 32'h0);

    // reset in WAIT with response during reset
    step();
    rst = 1'b0;
    #1;
    chk("t6_req", {31'h0, imem_req}, 32'h0);
    man_rvalid = 1'b1;
    man_rdata  = 32'h4444_4444;
    step();
    man_rvalid = 1'b0;
    chk("t6_state", 32'(u0.state), 32'(FETCH));
    chk("t6_pcreg", u0.pc, 32'h0);
    chk("t6_valid", {31'h0, valid_out}, 32'h0);
    chk("t6_pc", pc_out, 32'h0);
    chk("t6_instr", instruction_out, NOP);
    rst = 1'b1;
    #1;
    chk("t6_req2", {31'h0, imem_req}, 32'h1);
    chk("t6_addr2", imem_addr, 32'h0);

    // randomized run against the in-order delivery model
    auto_mem   = 1'b1;
    next_pc    = 32'h0;
    prev_valid = valid_out;
    prev_pc    = pc_out;
    prev_instr = instruction_out;
    redir_last = 1'b0;
    hold_last  = 1'b0;
    ndeliv     = 0;
    for (int i = 0; i < 3000; i++) begin
      step();
      if (redir_last) begin
        chk("rnd_redir_valid", {31'h0, valid_out}, 32'h0);
        chk("rnd_redir_instr", instruction_out, NOP);
      end else begin
        if (hold_last) begin
          chk("rnd_hold_valid", {31'h0, valid_out}, {31'h0, prev_valid});
          chk("rnd_hold_pc", pc_out, prev_pc);
          chk("rnd_hold_instr", instruction_out, prev_instr);
        end
        delivered = valid_out && (!prev_valid || pc_out != prev_pc);
        if (delivered) begin
          chk("rnd_pc", pc_out, next_pc);
          chk("rnd_instr", instruction_out, mem(next_pc));
          next_pc = next_pc + 32'd4;
          ndeliv++;
        end
      end
      if (!valid_out) chk("rnd_nop", instruction_out, NOP);
      if (imem_req) chk("rnd_addr", imem_addr, next_pc);
      prev_valid = valid_out;
      prev_pc    = pc_out;
      prev_instr = instruction_out;
      r = int'($urandom_range(0, 99));
      branch_taken  = (r < 6);
      flush         = (r >= 6 && r < 10);
      stall         = ($urandom_range(0, 99) < 30);
      branch_target = $urandom & 32'h0000_0FFF;
      if (branch_taken) next_pc = branch_target & ~32'h3;
      redir_last = branch_taken | flush;
      hold_last  = stall && !(branch_taken | flush);
    end
    branch_taken = 1'b0;
    flush = 1'b0;
    stall = 1'b0;
    chk("rnd_progress", {31'h0, ndeliv > 200}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
